uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between NUM_REQ byte producers (e.g. message generator, debug dump, status reporter).
- Round-robin arbitration per byte, with message locking so multi-byte messages never interleave.
- Drives the uart_tx i_byte_in/i_data_valid inputs and sequences each byte on that instance's o_tx_active/o_tx_done; sits between top-level producers and uart_tx.

---
 rtl/uart_tx_arbiter_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the uart_tx arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int unsigned UART_DATA_W = 8;
  // Oversampling factor used by the simulation uart_tx model.
  localparam int unsigned BAUD_MULT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_SEND   = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  // Increment with wrap at n (n >= 1).
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bus plus uart_tx handshake, shared by arbiter and environment.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]             i_req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] i_req_data;
  logic [NUM_REQ-1:0]             i_req_last;
  logic [NUM_REQ-1:0]             o_req_ready;
  logic [UART_DATA_W-1:0]         o_tx_byte;
  logic                           o_tx_valid;
  logic                           i_tx_active;
  logic                           i_tx_done;
  logic [ID_W-1:0]                o_grant_id;
  logic                           o_locked;
  logic                           o_busy;
  logic                           o_err_timeout;

  // Arbiter side.
  modport master (
    input  i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
    output o_req_ready, o_tx_byte, o_tx_valid, o_grant_id, o_locked, o_busy, o_err_timeout
  );

  // Producers and uart_tx side.
  modport slave (
    output i_req_valid, i_req_data, i_req_last, i_tx_active, i_tx_done,
    input  o_req_ready, o_tx_byte, o_tx_valid, o_grant_id, o_locked, o_busy, o_err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker with optional lock to a single owner.
module uart_tx_arbiter_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               lock_en,
  input  logic [ID_W-1:0]    lock_id,
  output logic               hit,
  output logic [ID_W-1:0]    win_id
);

  // Locked: only the owner may win; otherwise first valid from ptr upward with wrap.
  always_comb begin
    int unsigned k;
    hit    = 1'b0;
    win_id = '0;
    k      = 0;
    if (lock_en) begin
      hit    = req[lock_id];
      win_id = lock_id;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        k = (32'(ptr) + i) % NUM_REQ;
        if (!hit && req[ID_W'(k)]) begin
          hit    = 1'b1;
          win_id = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: per-byte round robin with message lock.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned LAUNCH_TIMEOUT = 64,
  parameter int unsigned GAP_CYCLES     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned CNT_MAX = (LAUNCH_TIMEOUT > GAP_CYCLES) ? LAUNCH_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   lock_q, lock_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [UART_DATA_W-1:0] byte_q, byte_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic [NUM_REQ-1:0]     ready_q, ready_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic                   pick_hit;
  logic [ID_W-1:0]        pick_id;
  logic [UART_DATA_W-1:0] req_byte [NUM_REQ];

  // Unpack the flat producer data bus.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = bus.i_req_data[g*UART_DATA_W +: UART_DATA_W];
  end

  // Lock owner is always the last grant, so grant_q doubles as the lock id.
  uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (bus.i_req_valid),
    .ptr     (ptr_q),
    .lock_en (lock_q),
    .lock_id (grant_q),
    .hit     (pick_hit),
    .win_id  (pick_id)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    last_d  = last_q;
    valid_d = 1'b0;
    ready_d = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.i_tx_active && !bus.i_tx_done && pick_hit) begin
          grant_d          = pick_id;
          byte_d           = req_byte[pick_id];
          last_d           = bus.i_req_last[pick_id];
          ready_d[pick_id] = 1'b1;
          cnt_d            = '0;
          state_d          = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (bus.i_tx_active) begin
          state_d = ST_SEND;
        end else if (cnt_q == CNT_W'(LAUNCH_TIMEOUT)) begin
          err_d   = 1'b1;
          lock_d  = 1'b0;
          ptr_d   = ID_W'(wrap_inc(32'(grant_q), NUM_REQ));
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (bus.i_tx_done) begin
          if (last_q) begin
            lock_d = 1'b0;
            ptr_d  = ID_W'(wrap_inc(32'(grant_q), NUM_REQ));
          end else begin
            lock_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = (GAP_CYCLES != 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (32'(cnt_q) + 32'd1 >= GAP_CYCLES) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      grant_q <= '0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_tx_valid    = valid_q;
  assign bus.o_tx_byte     = byte_q;
  assign bus.o_req_ready   = ready_q;
  assign bus.o_grant_id    = grant_q;
  assign bus.o_locked      = lock_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and a byte scoreboard.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned FRAME = 10 * BAUD_MULT;

  typedef struct packed {
    logic [7:0] b;
    logic [1:0] g;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ), .ID_W(2)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NREQ), .ID_W(2), .LAUNCH_TIMEOUT(8), .GAP_CYCLES(5)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  exp_t       sb [$];
  logic [8:0] pq [NREQ][$];
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Producers: pop on the ready pulse, present the next queued byte.
  logic [NREQ-1:0]   req_v = '0;
  logic [NREQ*8-1:0] req_d = '0;
  logic [NREQ-1:0]   req_l = '0;
  logic              v0_prev = 1'b0;
  int                t_req0 = 0;
  assign bus.i_req_valid = req_v;
  assign bus.i_req_data  = req_d;
  assign bus.i_req_last  = req_l;
  always @(negedge clk) begin
    for (int k = 0; k < int'(NREQ); k++) begin
      if (bus.o_req_ready[k] && pq[k].size() != 0) pq[k].delete(0);
      if (pq[k].size() != 0) begin
        req_v[k]        = 1'b1;
        req_l[k]        = pq[k][0][8];
        req_d[k*8 +: 8] = pq[k][0][7:0];
      end else begin
        req_v[k] = 1'b0;
        req_l[k] = 1'b0;
      end
    end
    if (req_v[0] && !v0_prev) t_req0 = cyc;
    v0_prev = req_v[0];
  end

  // Behavioural uart_tx: active the cycle after valid, done pulse as active falls.
  logic u_act  = 1'b0;
  logic u_done = 1'b0;
  logic mute   = 1'b0;
  int   ucnt   = 0;
  assign bus.i_tx_active = u_act;
  assign bus.i_tx_done   = u_done;
  always @(posedge clk) begin
    if (!u_act) begin
      u_done <= 1'b0;
      if (bus.o_tx_valid && !mute) begin
        u_act <= 1'b1;
        ucnt  <= 0;
      end
    end else if (ucnt == int'(FRAME) - 1) begin
      u_act  <= 1'b0;
      u_done <= 1'b1;
    end else begin
      ucnt <= ucnt + 1;
    end
  end

  // Launch guard as seen by the DUT at each active edge.
  logic guard_prev = 1'b0;
  always @(posedge clk) guard_prev = !bus.i_tx_active && !bus.i_tx_done;

  // Output monitor and scoreboard.
  logic prev_act = 1'b0, prev_valid = 1'b0;
  int   t_vrise = 0, t_vfall = 0, t_arise = 0, t_rdy0 = 0, last_done = 0, rise_gap = 0;
  int   valid_hi = 0, err_cnt = 0;
  int   ready_cnt [NREQ];
  initial for (int k = 0; k < int'(NREQ); k++) ready_cnt[k] = 0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.i_tx_active && !prev_act) begin
      t_arise = cyc;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("tx_byte", 32'(bus.o_tx_byte), 32'(e.b));
        chk("grant_id", 32'(bus.o_grant_id), 32'(e.g));
        chk("locked_at_launch", 32'(bus.o_locked), 32'(e.l));
      end
    end
    if (bus.i_tx_done) last_done = cyc;
    if (bus.o_tx_valid && !prev_valid) begin
      t_vrise  = cyc;
      rise_gap = cyc - last_done;
    end
    if (!bus.o_tx_valid && prev_valid) t_vfall = cyc;
    if (bus.o_tx_valid) valid_hi++;
    if (bus.o_err_timeout) err_cnt++;
    if (|bus.o_req_ready) begin
      chk("launch_guard", 32'(guard_prev), 32'd1);
      chk("ready_onehot", 32'($countones(bus.o_req_ready)), 32'd1);
    end
    for (int k = 0; k < int'(NREQ); k++) if (bus.o_req_ready[k]) ready_cnt[k]++;
    if (bus.o_req_ready[0]) t_rdy0 = cyc;
    prev_act   = bus.i_tx_active;
    prev_valid = bus.o_tx_valid;
  end

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic push(input int k, input logic last, input logic [7:0] b);
    pq[k].push_back({last, b});
  endtask

  task automatic wait_drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
          pq[3].size() == 0 && !bus.o_busy && !bus.i_tx_active && !bus.i_tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.o_tx_valid), 32'd0);
    chk({tag, "_byte"}, 32'(bus.o_tx_byte), 32'd0);
    chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'd0);
    chk({tag, "_grant"}, 32'(bus.o_grant_id), 32'd0);
    chk({tag, "_locked"}, 32'(bus.o_locked), 32'd0);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_err_timeout), 32'd0);
  endtask

  initial begin
    int   base_v, base_e, base_r;
    logic seen;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Single byte from requester 0.
    base_r = ready_cnt[0];
    @(posedge clk); #1;
    push(0, 1'b1, 8'h48);
    sb.push_back('{b: 8'h48, g: 2'd0, l: 1'b0});
    wait_drain("single_drain");
    chk("single_ready_pulses", 32'(ready_cnt[0] - base_r), 32'd1);
    chk("single_req_to_valid", 32'(t_vrise - t_req0), 32'd2);
    chk("single_ready_to_valid", 32'(t_vrise - t_rdy0), 32'd1);
    chk("single_valid_drop", 32'(t_vfall - t_arise), 32'd1);
    chk("single_busy_end", 32'(bus.o_busy), 32'd0);

    // Round robin over four single-byte producers.
    do_reset();
    @(posedge clk); #1;
    push(0, 1'b1, 8'h41); push(0, 1'b1, 8'h41);
    push(1, 1'b1, 8'h42); push(2, 1'b1, 8'h43); push(3, 1'b1, 8'h44);
    sb.push_back('{b: 8'h41, g: 2'd0, l: 1'b0});
    sb.push_back('{b: 8'h42, g: 2'd1, l: 1'b0});
    sb.push_back('{b: 8'h43, g: 2'd2, l: 1'b0});
    sb.push_back('{b: 8'h44, g: 2'd3, l: 1'b0});
    sb.push_back('{b: 8'h41, g: 2'd0, l: 1'b0});
    wait_drain("rr_drain");

    // Locked message from requester 1 while requester 2 waits.
    do_reset();
    @(posedge clk); #1;
    push(1, 1'b0, 8'h48); push(1, 1'b0, 8'h69); push(1, 1'b1, 8'h0A);
    push(2, 1'b1, 8'h52);
    sb.push_back('{b: 8'h48, g: 2'd1, l: 1'b0});
    sb.push_back('{b: 8'h69, g: 2'd1, l: 1'b1});
    sb.push_back('{b: 8'h0A, g: 2'd1, l: 1'b1});
    sb.push_back('{b: 8'h52, g: 2'd2, l: 1'b0});
    wait_drain("lock_drain");
    chk("lock_released", 32'(bus.o_locked), 32'd0);

    // Launch timeout while locked to requester 1.
    do_reset();
    @(posedge clk); #1;
    push(1, 1'b0, 8'h11);
    sb.push_back('{b: 8'h11, g: 2'd1, l: 1'b0});
    wait_drain("to_first_drain");
    chk("to_locked_before", 32'(bus.o_locked), 32'd1);
    base_v = valid_hi; base_e = err_cnt; base_r = ready_cnt[1];
    mute = 1'b1;
    @(posedge clk); #1;
    push(1, 1'b0, 8'h12);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (err_cnt != base_e) begin seen = 1'b1; break; end
    end
    chk("to_err_seen", 32'(seen), 32'd1);
    repeat (4) @(negedge clk);
    chk("to_valid_cycles", 32'(valid_hi - base_v), 32'd8);
    chk("to_err_pulses", 32'(err_cnt - base_e), 32'd1);
    chk("to_ready_pulses", 32'(ready_cnt[1] - base_r), 32'd1);
    chk("to_lock_cleared", 32'(bus.o_locked), 32'd0);
    chk("to_busy", 32'(bus.o_busy), 32'd0);
    mute = 1'b0;
    @(posedge clk); #1;
    push(0, 1'b1, 8'h20); push(2, 1'b1, 8'h22);
    sb.push_back('{b: 8'h22, g: 2'd2, l: 1'b0});
    sb.push_back('{b: 8'h20, g: 2'd0, l: 1'b0});
    wait_drain("to_after_drain");

    // Reset in the middle of a frame.
    do_reset();
    @(posedge clk); #1;
    push(3, 1'b0, 8'h55);
    sb.push_back('{b: 8'h55, g: 2'd3, l: 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.i_tx_active) begin seen = 1'b1; break; end
    end
    chk("rst_frame_started", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_zero_outputs("midrst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("midrst_uart_still_active", 32'(bus.i_tx_active), 32'd1);
    @(posedge clk); #1;
    push(0, 1'b1, 8'h5A);
    sb.push_back('{b: 8'h5A, g: 2'd0, l: 1'b0});
    wait_drain("midrst_drain");

    // Gap spacing between back-to-back bytes.
    do_reset();
    @(posedge clk); #1;
    push(0, 1'b1, 8'h61); push(1, 1'b1, 8'h62);
    sb.push_back('{b: 8'h61, g: 2'd0, l: 1'b0});
    sb.push_back('{b: 8'h62, g: 2'd1, l: 1'b0});
    wait_drain("gap_drain");
    chk("gap_done_to_valid_ge8", 32'(rise_gap >= 8), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
